// File: rtl/weight_sign_sram_loader_lenet_if.sv
// Sign-word stream into the LeNet weight-sign SRAM loader (AXI-Stream style valid/ready/last).
interface weight_sign_sram_loader_lenet_if #(
    parameter int W = 16
) ();
    logic [W-1:0] s_tdata;
    logic         s_tvalid;
    logic         s_tready;
    logic         s_tlast;

    modport master (output s_tdata, output s_tvalid, output s_tlast, input s_tready);
    modport slave  (input s_tdata, input s_tvalid, input s_tlast, output s_tready);
endinterface

// File: rtl/weight_sign_sram_loader_lenet.sv
// Streams 16-bit sign words into one layer's region of the weight-sign SRAM and checks stream length.
// Optional running-XOR checksum output enabled by defining WEIGHT_SIGN_LOADER_CHECKSUM_EN.
module weight_sign_sram_loader_lenet #(
    parameter int WEIGHT_SIGN_BITWIDTH = 16,
    parameter int WEIGHT_CYCLE_NUM_1   = 14700,
    parameter int WEIGHT_CYCLE_NUM_2   = 1900,
    parameter int WEIGHT_CYCLE_NUM_3   = 70,
    localparam int MEM_LEN = WEIGHT_CYCLE_NUM_1 + WEIGHT_CYCLE_NUM_2 + WEIGHT_CYCLE_NUM_3,
    localparam int ADDR_W  = $clog2(MEM_LEN)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [2:0]                      layer,
    input  logic                            load_start,
    weight_sign_sram_loader_lenet_if.slave  s,
    output logic                            mem_wr_en,
    output logic [ADDR_W-1:0]               mem_wr_addr,
    output logic [WEIGHT_SIGN_BITWIDTH-1:0] mem_wr_data,
    output logic                            busy,
    output logic                            load_done,
    output logic                            load_error
`ifdef WEIGHT_SIGN_LOADER_CHECKSUM_EN
    ,
    output logic [WEIGHT_SIGN_BITWIDTH-1:0] checksum
`endif
);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

    localparam logic [ADDR_W-1:0] BASE_1 = '0;
    localparam logic [ADDR_W-1:0] BASE_2 = ADDR_W'(WEIGHT_CYCLE_NUM_1);
    localparam logic [ADDR_W-1:0] BASE_3 = ADDR_W'(WEIGHT_CYCLE_NUM_1 + WEIGHT_CYCLE_NUM_2);
    localparam logic [ADDR_W-1:0] LAST_1 = ADDR_W'(WEIGHT_CYCLE_NUM_1 - 1);
    localparam logic [ADDR_W-1:0] LAST_2 = ADDR_W'(WEIGHT_CYCLE_NUM_2 - 1);
    localparam logic [ADDR_W-1:0] LAST_3 = ADDR_W'(WEIGHT_CYCLE_NUM_3 - 1);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] base, len_m1, cnt;
    logic [ADDR_W-1:0] base_sel, len_m1_sel;
    logic              layer_ok, start_ok, start_bad, hs, write, last_cnt;

    assign s.s_tready = (state != IDLE);
    assign busy       = (state != IDLE);
    assign hs         = s.s_tvalid & s.s_tready;
    assign write      = (state == LOAD) && hs;
    assign last_cnt   = (cnt == len_m1);
    assign layer_ok   = (layer == 3'b001) || (layer == 3'b010) || (layer == 3'b100);
    assign start_ok   = (state == IDLE) && load_start && layer_ok;
    assign start_bad  = (state == IDLE) && load_start && !layer_ok;

    always_comb begin
        base_sel   = BASE_1;
        len_m1_sel = LAST_1;
        case (layer)
            3'b010: begin base_sel = BASE_2; len_m1_sel = LAST_2; end
            3'b100: begin base_sel = BASE_3; len_m1_sel = LAST_3; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // A stream that overruns its layer keeps being accepted in DRAIN so the host is never stalled.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (start_ok) state_nx = LOAD;
            LOAD: begin
                if (hs) begin
                    if (s.s_tlast)     state_nx = IDLE;
                    else if (last_cnt) state_nx = DRAIN;
                end
            end
            DRAIN: if (hs && s.s_tlast) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base        <= '0;
            len_m1      <= '0;
            cnt         <= '0;
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
            load_done   <= 1'b0;
            load_error  <= 1'b0;
        end else begin
            mem_wr_en <= 1'b0;
            load_done <= 1'b0;
            if (start_ok) begin
                base       <= base_sel;
                len_m1     <= len_m1_sel;
                cnt        <= '0;
                load_error <= 1'b0;
            end else if (start_bad) begin
                load_error <= 1'b1;
            end
            if (write) begin
                mem_wr_en   <= 1'b1;
                mem_wr_addr <= base + cnt;
                mem_wr_data <= s.s_tdata;
                cnt         <= cnt + ADDR_W'(1);
                if (last_cnt && s.s_tlast)      load_done  <= 1'b1;
                else if (last_cnt || s.s_tlast) load_error <= 1'b1;
            end
        end
    end

`ifdef WEIGHT_SIGN_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        checksum <= '0;
        else if (start_ok) checksum <= '0;
        else if (write)    checksum <= checksum ^ s.s_tdata;
    end
`endif

endmodule

// File: tb/tb_weight_sign_sram_loader_lenet.sv
// Directed + randomized bench for weight_sign_sram_loader_lenet with small layer sizes (8/4/2).
module tb_weight_sign_sram_loader_lenet;
    localparam int W  = 16;
    localparam int N1 = 8;
    localparam int N2 = 4;
    localparam int N3 = 2;
    localparam int AW = $clog2(N1 + N2 + N3);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [2:0]    layer = 3'b000;
    logic          load_start = 1'b0;
    logic          mem_wr_en;
    logic [AW-1:0] mem_wr_addr;
    logic [W-1:0]  mem_wr_data;
    logic          busy, load_done, load_error;
`ifdef WEIGHT_SIGN_LOADER_CHECKSUM_EN
    logic [W-1:0]  checksum;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state for the load in progress
    int           lens [3] = '{N1, N2, N3};
    int           m_base, m_len, m_n, m_idx;
    logic [W-1:0] m_xor;
    logic [W-1:0] pat [4] = '{16'h00F0, 16'h0F00, 16'hF000, 16'h000F};

    weight_sign_sram_loader_lenet_if #(.W(W)) s_if ();

    weight_sign_sram_loader_lenet #(
        .WEIGHT_SIGN_BITWIDTH(W),
        .WEIGHT_CYCLE_NUM_1(N1),
        .WEIGHT_CYCLE_NUM_2(N2),
        .WEIGHT_CYCLE_NUM_3(N3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .layer(layer),
        .load_start(load_start),
        .s(s_if),
        .mem_wr_en(mem_wr_en),
        .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data),
        .busy(busy),
        .load_done(load_done),
        .load_error(load_error)
`ifdef WEIGHT_SIGN_LOADER_CHECKSUM_EN
        ,
        .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_load(input int li, input int n);
        m_base = 0;
        for (int k = 0; k < li - 1; k++) m_base += lens[k];
        m_len = lens[li-1];
        m_n   = n;
        m_idx = 0;
        m_xor = '0;
        layer      = 3'(1 << (li - 1));
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        check("start_busy", busy, 1);
        check("start_err_clr", load_error, 0);
        check("start_no_wr", mem_wr_en, 0);
`ifdef WEIGHT_SIGN_LOADER_CHECKSUM_EN
        check("start_csum_clr", checksum, 0);
`endif
    endtask

    task automatic idle_cycles(input int g);
        for (int k = 0; k < g; k++) begin
            s_if.s_tvalid = 1'b0;
            @(negedge clk);
            check("gap_no_wr", mem_wr_en, 0);
            check("gap_no_done", load_done, 0);
        end
    endtask

    task automatic send_word(input logic [W-1:0] d, input bit last);
        bit wr, exp_err;
        int lim;
        check("tready", s_if.s_tready, 1);
        s_if.s_tdata  = d;
        s_if.s_tvalid = 1'b1;
        s_if.s_tlast  = last;
        @(negedge clk);
        wr      = (m_idx < m_len);
        lim     = (m_n < m_len) ? m_n : m_len;
        exp_err = (m_n != m_len) && (m_idx >= lim - 1);
        check("wr_en", mem_wr_en, 32'(wr));
        if (wr) begin
            check("wr_addr", 32'(mem_wr_addr), 32'(m_base + m_idx));
            check("wr_data", 32'(mem_wr_data), 32'(d));
            m_xor = m_xor ^ d;
        end
        check("done", load_done, 32'(wr && last && (m_idx == m_len - 1)));
        check("busy", busy, 32'(!last));
        check("err", load_error, 32'(exp_err));
        m_idx++;
    endtask

    task automatic run_load(input int li, input int n, input int gmin, input int gmax, input int mode);
        logic [W-1:0] d;
        start_load(li, n);
        for (int i = 0; i < n; i++) begin
            idle_cycles(int'($urandom_range(gmax, gmin)));
            if (mode == 1)      d = W'(i + 1);
            else if (mode == 2) d = pat[i % 4];
            else                d = W'($urandom);
            if (i == 1) begin
                layer      = 3'($urandom);
                load_start = 1'b1;
            end
            send_word(d, i == n - 1);
            load_start = 1'b0;
        end
        s_if.s_tvalid = 1'b0;
        s_if.s_tlast  = 1'b0;
        @(negedge clk);
        check("end_no_wr", mem_wr_en, 0);
        check("end_no_done", load_done, 0);
        check("end_idle", busy, 0);
        check("end_err", load_error, 32'(n != lens[li-1]));
`ifdef WEIGHT_SIGN_LOADER_CHECKSUM_EN
        check("end_csum", 32'(checksum), 32'(m_xor));
`endif
    endtask

    task automatic bad_start(input logic [2:0] lay);
        layer      = lay;
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        check("bad_err", load_error, 1);
        check("bad_busy", busy, 0);
        check("bad_no_wr", mem_wr_en, 0);
        @(negedge clk);
        check("bad_still_idle", busy, 0);
        check("bad_err_sticky", load_error, 1);
    endtask

    initial begin
        s_if.s_tdata  = '0;
        s_if.s_tvalid = 1'b0;
        s_if.s_tlast  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_wr_en", mem_wr_en, 0);
        check("rst_addr", 32'(mem_wr_addr), 0);
        check("rst_data", 32'(mem_wr_data), 0);
        check("rst_busy", busy, 0);
        check("rst_done", load_done, 0);
        check("rst_err", load_error, 0);
        check("rst_tready", s_if.s_tready, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_load(1, N1, 0, 0, 1);         // full layer 1, back-to-back, 1..8
        run_load(3, N3, 3, 3, 0);         // layer 3 with 3-cycle gap
        run_load(2, 3, 0, 1, 0);          // short stream
        run_load(3, 4, 0, 1, 0);          // long stream, drained
        bad_start(3'b011);
        bad_start(3'b000);
        run_load(2, N2, 0, 1, 2);         // checksum pattern, clears sticky error
`ifdef WEIGHT_SIGN_LOADER_CHECKSUM_EN
        check("csum_pattern", 32'(checksum), 32'h0000_FFFF);
`endif
        for (int r = 0; r < 10; r++) begin
            int li;
            li = int'($urandom_range(3, 1));
            run_load(li, int'($urandom_range(lens[li-1] + 2, 1)), 0, 2, 0);
        end

        // Reset in the middle of a layer-1 load
        start_load(1, N1);
        send_word(W'($urandom), 1'b0);
        send_word(W'($urandom), 1'b0);
        s_if.s_tvalid = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_wr_en", mem_wr_en, 0);
        check("mid_rst_addr", 32'(mem_wr_addr), 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_tready", s_if.s_tready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post_rst_no_wr", mem_wr_en, 0);
            check("post_rst_idle", busy, 0);
        end
        s_if.s_tvalid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/weight_sign_sram_loader_lenet.md
Name: weight_sign_sram_loader_lenet

Overview:
- Write-side companion of the LeNet weight-sign SRAM.
- Accepts a stream of 16-bit sign words from the host/packet path and writes them into the sign memory region of one layer.
- Each layer has a fixed base address (layer 1 at 0, layer 2 at WEIGHT_CYCLE_NUM_1, layer 3 at WEIGHT_CYCLE_NUM_1+WEIGHT_CYCLE_NUM_2), matching the read-side layout.
- Checks the stream length against the expected per-layer word count and reports done or error.

Parameters:
- WEIGHT_SIGN_BITWIDTH, 16, width of one sign word / SRAM row.
- WEIGHT_CYCLE_NUM_1, 14700, number of layer-1 words.
- WEIGHT_CYCLE_NUM_2, 1900, number of layer-2 words.
- WEIGHT_CYCLE_NUM_3, 70, number of layer-3 words.
- MEM_LEN (localparam), sum of the three counts; ADDR_W = $clog2(MEM_LEN).

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- layer  in  3  one-hot layer select (001/010/100), sampled on load_start.
- load_start  in  1  single-cycle request to begin loading a layer.
- s_tdata  in  WEIGHT_SIGN_BITWIDTH  incoming sign word.
- s_tvalid  in  1  word valid.
- s_tready  out  1  loader can accept.
- s_tlast  in  1  marks final word of the stream.
- mem_wr_en  out  1  SRAM write strobe.
- mem_wr_addr  out  ADDR_W  SRAM write address.
- mem_wr_data  out  WEIGHT_SIGN_BITWIDTH  SRAM write data.
- busy  out  1  high in LOAD or DRAIN.
- load_done  out  1  one-cycle pulse on successful completion.
- load_error  out  1  sticky error flag; cleared by the next accepted load_start.

Behaviour:
- Reset: all outputs and state go to 0 / IDLE asynchronously. Reset mid-load aborts the load with no further writes; partial SRAM contents are left as written.
- States: IDLE, LOAD, DRAIN.
- IDLE:
  - s_tready=0.
  - On load_start with a valid one-hot layer: latch base address and expected length LEN; clear word counter cnt and load_error; go to LOAD.
  - On load_start with an invalid layer (not exactly one bit set): set load_error, stay in IDLE.
- LOAD:
  - s_tready=1. A handshake is s_tvalid&s_tready.
  - Each handshake registers mem_wr_en=1, mem_wr_addr=base+cnt and mem_wr_data=s_tdata on the next clock (1-cycle write latency), then increments cnt.
  - With no handshake, mem_wr_en=0 the next cycle; address and data hold.
  - Handshake with cnt==LEN-1 and s_tlast=1: the word is written; load_done pulses in the same cycle as that final mem_wr_en; go to IDLE.
  - Handshake with s_tlast=1 and cnt<LEN-1 (short stream): the word is written; set load_error; go to IDLE; no load_done.
  - Handshake with cnt==LEN-1 and s_tlast=0 (long stream): the word is written; set load_error; go to DRAIN.
- DRAIN: s_tready=1; no writes; words are discarded until a handshake with s_tlast=1, then go to IDLE.
- load_start is ignored while busy.
- Addresses never exceed base+LEN-1 and never cross into another layer's region.
- Arithmetic: cnt is ADDR_W wide; base+cnt is unsigned with no wrap, because MEM_LEN bounds it.

Optional Feature:
- Macro: WEIGHT_SIGN_LOADER_CHECKSUM_EN.
- Defined:
  - Adds output checksum [WEIGHT_SIGN_BITWIDTH-1:0], the running XOR of every word written in the current load.
  - Cleared on an accepted load_start; valid when load_done pulses; holds until the next accepted load_start; reset to 0.
  - Words discarded in DRAIN are not included.
- Undefined: no checksum port or logic; behaviour is otherwise identical.

Test Plan (NUM_1=8, NUM_2=4, NUM_3=2):
- Layer-1 load:
  - Stimulus: layer=001, load_start, 8 words 0x0001..0x0008 streamed back-to-back, tlast on the 8th.
  - Response: writes to addr 0..7 with matching data, each 1 cycle after its handshake; load_done pulses once with the addr-7 write; load_error=0.
- Layer-3 load with gaps:
  - Stimulus: layer=100, 2 words with tvalid low for 3 cycles between them.
  - Response: writes at addr 12 and 13; mem_wr_en low during the gap; load_done pulses.
- Short stream:
  - Stimulus: layer=010, tlast on the 3rd word.
  - Response: writes at addr 8..10; load_error=1; no load_done; back to IDLE. A following valid load_start clears load_error.
- Long stream:
  - Stimulus: layer=100, 4 words, tlast on the 4th.
  - Response: writes only at addr 12..13; words 3–4 accepted and dropped; load_error=1; busy drops after the 4th handshake.
- Invalid layer and reset:
  - Stimulus: layer=011 with load_start.
  - Response: load_error=1, busy=0, no writes.
  - Stimulus: rst_n asserted low after the 2nd word of a layer-1 load.
  - Response: all outputs 0 immediately; no writes after reset.
- Checksum (with WEIGHT_SIGN_LOADER_CHECKSUM_EN):
  - Stimulus: layer-2 words 0x00F0, 0x0F00, 0xF000, 0x000F.
  - Response: checksum=0xFFFF at load_done.
